// File: rtl/prev_frame_store_pkg.sv
// Shared constants for the previous-frame grey store: luma coefficients,
// capture FSM encoding and address sizing helpers.
package prev_frame_store_pkg;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  typedef enum logic {
    ST_WAIT_VSYNC = 1'b0,
    ST_RUN        = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Number of stored samples in one decimated frame.
  function automatic int addr_size(input int h_active, input int v_active, input int decim_log2);
    return (h_active >> decim_log2) * (v_active >> decim_log2);
  endfunction

endpackage

// File: rtl/prev_frame_store_grey_bram_sdp.sv
// Simple dual-port 8-bit RAM: one write port, one read port with a
// registered read (one cycle latency). Contents are not reset.
module grey_bram_sdp #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [7:0]            wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [7:0]            rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/prev_frame_store.sv
// Converts RGB to grey, stores a decimated grey frame in ping-pong banks and
// emits the video stream 2 cycles late with aligned current/previous grey.
module prev_frame_store
  import prev_frame_store_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int DECIM_LOG2 = 2,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_vid_data,
  input  logic                  i_vid_hsync,
  input  logic                  i_vid_vsync,
  input  logic                  i_vid_VDE,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  output logic [7:0]            o_curr_grey,
  output logic [7:0]            o_prev_grey,
  output logic                  o_prev_valid
);

  // Counters carry one spare bit and saturate so oversize input never wraps back in range.
  localparam int XW = clog2(H_ACTIVE + 1) + 1;
  localparam int YW = clog2(V_ACTIVE + 1) + 1;
  localparam logic [XW-1:0]         X_LIM     = XW'(H_ACTIVE);
  localparam logic [YW-1:0]         Y_LIM     = YW'(V_ACTIVE);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(H_ACTIVE >> DECIM_LOG2);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(addr_size(H_ACTIVE, V_ACTIVE, DECIM_LOG2) - 1);

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic                  bank_sel_q, bank_sel_d;
  logic                  prev_valid_q, prev_valid_d;
  logic                  vsync_prev_q, vde_prev_q;

  logic                  vs_rise, vde_fall, run, in_range, sample_pt;
  logic [15:0]           grey_sum;
  logic [7:0]            grey;
  logic [ADDR_WIDTH-1:0] addr;

  logic [DATA_WIDTH-1:0] data_s1_q, data_s2_q;
  logic                  hsync_s1_q, vsync_s1_q, vde_s1_q;
  logic                  hsync_s2_q, vsync_s2_q, vde_s2_q;
  logic [7:0]            grey_s1_q, curr_grey_s2_q;
  logic [ADDR_WIDTH-1:0] addr_s1_q;
  logic                  we_s1_q, re_s1_q, bank_s1_q, pv_s1_q;
  logic                  bank_s2_q, pv_s2_q;
  logic [7:0]            bank_rd_data [2];

  assign grey_sum = 16'(COEF_R) * 16'(i_vid_data[DATA_WIDTH-1 -: 8])
                  + 16'(COEF_G) * 16'(i_vid_data[15:8])
                  + 16'(COEF_B) * 16'(i_vid_data[7:0]);
  assign grey     = 8'(grey_sum >> 8);

  assign vs_rise   = i_vid_vsync & ~vsync_prev_q;
  assign vde_fall  = ~i_vid_VDE & vde_prev_q;
  assign run       = (state_q == ST_RUN);
  assign in_range  = (x_q < X_LIM) && (y_q < Y_LIM);
  assign sample_pt = (x_q[DECIM_LOG2-1:0] == '0) && (y_q[DECIM_LOG2-1:0] == '0);
  assign addr      = in_range ? row_base_q + ADDR_WIDTH'(x_q >> DECIM_LOG2) : LAST_ADDR;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    row_base_d   = row_base_q;
    bank_sel_d   = bank_sel_q;
    prev_valid_d = prev_valid_q;
    if (vs_rise) begin
      x_d        = '0;
      y_d        = '0;
      row_base_d = '0;
      if (state_q == ST_WAIT_VSYNC) begin
        state_d = ST_RUN;
      end else begin
        // The finished frame is only usable if every active line arrived.
        bank_sel_d   = ~bank_sel_q;
        prev_valid_d = (y_q >= Y_LIM);
      end
    end else if (vde_fall) begin
      x_d = '0;
      if (y_q != '1) y_d = y_q + 1'b1;
      if (y_q[DECIM_LOG2-1:0] == '1) row_base_d = row_base_q + ROW_STEP;
    end else if (i_vid_VDE && (x_q != '1)) begin
      x_d = x_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_WAIT_VSYNC;
      x_q            <= '0;
      y_q            <= '0;
      row_base_q     <= '0;
      bank_sel_q     <= 1'b0;
      prev_valid_q   <= 1'b0;
      vsync_prev_q   <= 1'b0;
      vde_prev_q     <= 1'b0;
      data_s1_q      <= '0;
      hsync_s1_q     <= 1'b0;
      vsync_s1_q     <= 1'b0;
      vde_s1_q       <= 1'b0;
      grey_s1_q      <= '0;
      addr_s1_q      <= '0;
      we_s1_q        <= 1'b0;
      re_s1_q        <= 1'b0;
      bank_s1_q      <= 1'b0;
      pv_s1_q        <= 1'b0;
      data_s2_q      <= '0;
      hsync_s2_q     <= 1'b0;
      vsync_s2_q     <= 1'b0;
      vde_s2_q       <= 1'b0;
      curr_grey_s2_q <= '0;
      bank_s2_q      <= 1'b0;
      pv_s2_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      row_base_q     <= row_base_d;
      bank_sel_q     <= bank_sel_d;
      prev_valid_q   <= prev_valid_d;
      vsync_prev_q   <= i_vid_vsync;
      vde_prev_q     <= i_vid_VDE;
      data_s1_q      <= i_vid_data;
      hsync_s1_q     <= i_vid_hsync;
      vsync_s1_q     <= i_vid_vsync;
      vde_s1_q       <= i_vid_VDE;
      grey_s1_q      <= grey;
      addr_s1_q      <= addr;
      we_s1_q        <= run & i_vid_VDE & in_range & sample_pt;
      re_s1_q        <= run & i_vid_VDE;
      bank_s1_q      <= bank_sel_q;
      pv_s1_q        <= prev_valid_q;
      data_s2_q      <= data_s1_q;
      hsync_s2_q     <= hsync_s1_q;
      vsync_s2_q     <= vsync_s1_q;
      vde_s2_q       <= vde_s1_q;
      curr_grey_s2_q <= vde_s1_q ? grey_s1_q : 8'd0;
      bank_s2_q      <= bank_s1_q;
      pv_s2_q        <= pv_s1_q;
    end
  end

  // Bank gi is written while it is the capture bank and read while it is not.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK_ID = 1'(gi);
    grey_bram_sdp #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bram (
      .clk       (clk),
      .wr_en_i   (we_s1_q && (bank_s1_q == BANK_ID)),
      .wr_addr_i (addr_s1_q),
      .wr_data_i (grey_s1_q),
      .rd_en_i   (re_s1_q && (bank_s1_q != BANK_ID)),
      .rd_addr_i (addr_s1_q),
      .rd_data_o (bank_rd_data[gi])
    );
  end

  assign o_vid_data   = data_s2_q;
  assign o_vid_hsync  = hsync_s2_q;
  assign o_vid_vsync  = vsync_s2_q;
  assign o_vid_VDE    = vde_s2_q;
  assign o_curr_grey  = curr_grey_s2_q;
  assign o_prev_valid = pv_s2_q;
  assign o_prev_grey  = (vde_s2_q && pv_s2_q) ? bank_rd_data[~bank_s2_q] : 8'd0;

endmodule
